// File: rtl/mt9v034_lvds_sync_decode.sv
// MT9V034 LVDS embedded-sync decoder: turns the aligned 18-bit packet stream into
// pixel-valid data with frame/line pulses, geometry/framing checks and a good-frame count.
module mt9v034_lvds_sync_decode #(
  parameter int         TCQ      = 100,
  parameter logic [9:0] SOF_CODE = 10'h3FF,
  parameter logic [9:0] SOL_CODE = 10'h3FE,
  parameter logic [9:0] EOL_CODE = 10'h3FD,
  parameter logic [9:0] EOF_CODE = 10'h3FC,
  parameter int         H_ACTIVE = 752,
  parameter int         V_ACTIVE = 480
) (
  input  logic        dlo_clk,
  input  logic        rst,
  input  logic        dlo_valid_i,
  input  logic [17:0] dlo_i,
  output logic        pix_valid,
  output logic [9:0]  pix_data,
  output logic        sof,
  output logic        eol,
  output logic        eof,
  output logic [9:0]  line_cnt,
  output logic        geom_err,
  output logic        pkt_err,
  output logic        link_err,
  output logic [15:0] frame_cnt
);

  localparam logic [2:0] S_WAIT  = 3'b001;
  localparam logic [2:0] S_FRAME = 3'b010;
  localparam logic [2:0] S_LINE  = 3'b100;

  localparam logic [9:0] H_MAX  = 10'(H_ACTIVE);
  localparam logic [9:0] V_CNT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE - 1);

  // Clock-to-Q is modelled by the surrounding testbench, not in this RTL.
  localparam int unused_tcq = TCQ;

  // Stage 1 keeps only the marker bits and the code/pixel field.
  logic        v_q;
  logic [11:0] w_q;
  logic        unused_bits;
  assign unused_bits = ^dlo_i[16:11];

  logic [2:0] state_q, state_d;
  logic [9:0] pix_q, pix_d;
  logic [9:0] line_q, line_d;
  logic       bad_q, bad_d;

  logic [9:0] c;
  logic       mark_ok, hit_sof, hit_sol, hit_eol, hit_eof, is_data;
  logic       emit, sof_d, eol_d, eof_d, frame_ctl;
  logic       geom_set, pkt_set, link_set, good_frame;

  assign c       = w_q[10:1];
  assign mark_ok = w_q[0] & ~w_q[11];
  assign hit_sof = mark_ok & (c == SOF_CODE);
  assign hit_sol = mark_ok & (c == SOL_CODE);
  assign hit_eol = mark_ok & (c == EOL_CODE);
  assign hit_eof = mark_ok & (c == EOF_CODE);
  assign is_data = mark_ok & ~(hit_sof | hit_sol | hit_eol | hit_eof);

  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    line_d     = line_q;
    bad_d      = bad_q;
    emit       = 1'b0;
    sof_d      = 1'b0;
    eol_d      = 1'b0;
    eof_d      = 1'b0;
    frame_ctl  = 1'b0;
    geom_set   = 1'b0;
    pkt_set    = 1'b0;
    link_set   = 1'b0;
    good_frame = 1'b0;

    if (v_q) begin
      pkt_set = ~mark_ok;
      case (state_q)
        S_WAIT: begin
          if (hit_sof) begin
            state_d = S_FRAME;
            line_d  = '0;
            bad_d   = 1'b0;
          end
        end
        S_FRAME: begin
          if (hit_sol) begin
            state_d = S_LINE;
            pix_d   = '0;
          end else if (hit_sof | hit_eof) begin
            frame_ctl = 1'b1;
          end
        end
        S_LINE: begin
          if (is_data) begin
            emit  = 1'b1;
            sof_d = (pix_q == '0) && (line_q == '0);
            if (pix_q == H_MAX) begin
              geom_set = 1'b1;
            end else begin
              pix_d = pix_q + 10'd1;
              // Pulses are driven by count so they land on the pixel, not the later code.
              if (pix_q + 10'd1 == H_MAX) begin
                eol_d = 1'b1;
                eof_d = (line_q == V_LAST);
              end
            end
          end else if (hit_eol) begin
            state_d = S_FRAME;
            if (line_q != 10'h3FF) line_d = line_q + 10'd1;
            if (pix_q != H_MAX) geom_set = 1'b1;
          end else if (hit_sof | hit_eof) begin
            geom_set  = 1'b1;
            frame_ctl = 1'b1;
          end
        end
        default: state_d = S_WAIT;
      endcase

      if (frame_ctl) begin
        if (hit_sof) begin
          geom_set = 1'b1;
          state_d  = S_FRAME;
          line_d   = '0;
        end else begin
          state_d = S_WAIT;
          if (line_q != V_CNT) geom_set = 1'b1;
          else if (!bad_q && !geom_set) good_frame = 1'b1;
        end
      end
    end else if (state_q != S_WAIT) begin
      link_set = 1'b1;
      state_d  = S_WAIT;
    end

    // A restarted frame starts clean; otherwise any error spoils the current frame.
    if (frame_ctl && hit_sof) bad_d = 1'b0;
    else if (geom_set || pkt_set) bad_d = 1'b1;
  end

  always_ff @(posedge dlo_clk) begin
    if (rst) begin
      v_q       <= 1'b0;
      w_q       <= '0;
      state_q   <= S_WAIT;
      pix_q     <= '0;
      line_q    <= '0;
      bad_q     <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
      line_cnt  <= '0;
      geom_err  <= 1'b0;
      pkt_err   <= 1'b0;
      link_err  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      v_q       <= dlo_valid_i;
      w_q       <= {dlo_i[17], dlo_i[10:0]};
      state_q   <= state_d;
      pix_q     <= pix_d;
      line_q    <= line_d;
      bad_q     <= bad_d;
      pix_valid <= emit;
      if (emit) pix_data <= c;
      sof       <= sof_d;
      eol       <= eol_d;
      eof       <= eof_d;
      line_cnt  <= line_q;
      geom_err  <= geom_err | geom_set;
      pkt_err   <= pkt_err | pkt_set;
      link_err  <= link_err | link_set;
      if (good_frame) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
